uart_cmd_bridge: RTL and testbench

Serial host link that feeds the pipeline's command byte interface. Deserializes 8N1 UART frames from the host into a buffered valid/ready byte stream for the command input, and serializes the pipeline's command output byte stream back to the host. Sits directly upstream of the pipeline's cmd_in port and downstream of its cmd_out port, in the system clock domain.

---
 rtl/uart_pkg.sv | 24 ++
 rtl/uart_rx_fifo.sv | 55 +++++
 rtl/uart_cmd_bridge.sv | 208 ++++++++++++++++++++
 tb/tb_uart_cmd_bridge.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types for the UART host bridge: byte type, RX/TX state encodings and
// the break length multiplier (break = BREAK_LEN_MULT bit times of continuous low).
package uart_pkg;

    typedef logic [7:0] byte_t;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP,
        RX_WAIT_IDLE
    } uart_rx_state_t;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } uart_tx_state_t;

    localparam int BREAK_LEN_MULT = 20;

endpackage

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through byte FIFO; DEPTH must be a power of two so the
// pointers wrap naturally. A push into a full FIFO is accepted only with a pop.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       push,
    input  logic [7:0] push_data,
    input  logic       pop,
    output logic [7:0] pop_data,
    output logic       full,
    output logic       empty
);

    localparam int AW = $clog2(DEPTH);

    byte_t          mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [AW:0]    count;
    logic           do_push;
    logic           do_pop;

    assign full     = (count == (AW+1)'(DEPTH));
    assign empty    = (count == '0);
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign pop_data = empty ? 8'h00 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_cmd_bridge.sv
// 8N1 UART <-> valid/ready byte bridge for the pipeline command ports.
// Define BREAK_DETECT_EN to add line-break detection on host_break.
module uart_cmd_bridge
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT  = 100,
    parameter int RX_FIFO_DEPTH = 16
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       uart_rx,
    output logic       uart_tx,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic [7:0] rx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic [7:0] tx_data,
    output logic       rx_frame_err,
    output logic       rx_overrun,
    output logic       host_break
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT/2 - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(CLKS_PER_BIT - 1);

    // ---------------- RX ----------------
    logic           rx_meta, rx_sync;
    uart_rx_state_t rx_state, rx_state_nxt;
    logic [CW-1:0]  rx_cnt;
    logic [2:0]     rx_bit;
    byte_t          rx_shift;
    logic           rx_mid, rx_full;
    logic           rx_push, frame_err_set, overrun_set, brk_hit;
    logic           fifo_full, fifo_empty;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= uart_rx;
            rx_sync <= rx_meta;
        end
    end

    assign rx_mid  = (rx_cnt == CNT_HALF);
    assign rx_full = (rx_cnt == CNT_FULL);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) rx_state <= RX_IDLE;
        else       rx_state <= rx_state_nxt;
    end

    always_comb begin
        rx_state_nxt = rx_state;
        case (rx_state)
            RX_IDLE:      if (!rx_sync) rx_state_nxt = RX_START;
            RX_START:     if (rx_mid) rx_state_nxt = rx_sync ? RX_IDLE : RX_DATA;
            RX_DATA:      if (rx_full && rx_bit == 3'd7) rx_state_nxt = RX_STOP;
            RX_STOP:      if (rx_full) rx_state_nxt = rx_sync ? RX_IDLE : RX_WAIT_IDLE;
            RX_WAIT_IDLE: if (rx_sync) rx_state_nxt = RX_IDLE;
            default:      rx_state_nxt = RX_IDLE;
        endcase
        if (brk_hit) rx_state_nxt = RX_WAIT_IDLE;
    end

    // A break needs rx_sync low, so it can never coincide with a good stop bit.
    always_comb begin
        rx_push       = (rx_state == RX_STOP) && rx_full && rx_sync;
        frame_err_set = (rx_state == RX_STOP) && rx_full && !rx_sync;
        overrun_set   = rx_push && fifo_full && !(rx_valid && rx_ready);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_shift <= '0;
        end else begin
            case (rx_state)
                RX_START: begin
                    if (rx_mid) begin
                        rx_cnt <= '0;
                        rx_bit <= '0;
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (rx_full) begin
                        rx_cnt   <= '0;
                        rx_bit   <= rx_bit + 1'b1;
                        rx_shift <= {rx_sync, rx_shift[7:1]};
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                RX_STOP: rx_cnt <= rx_full ? '0 : rx_cnt + 1'b1;
                default: rx_cnt <= '0;
            endcase
        end
    end

`ifdef BREAK_DETECT_EN
    localparam int BRK_LEN = BREAK_LEN_MULT * CLKS_PER_BIT;
    localparam int BW      = $clog2(BRK_LEN + 1);
    logic [BW-1:0] brk_cnt;

    // Saturates at BRK_LEN so a long break reports only once.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)                        brk_cnt <= '0;
        else if (rx_sync)                 brk_cnt <= '0;
        else if (brk_cnt != BW'(BRK_LEN)) brk_cnt <= brk_cnt + 1'b1;
    end

    assign brk_hit = !rx_sync && (brk_cnt == BW'(BRK_LEN - 1));
`else
    assign brk_hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rx_frame_err <= 1'b0;
            rx_overrun   <= 1'b0;
            host_break   <= 1'b0;
        end else begin
            rx_frame_err <= frame_err_set;
            rx_overrun   <= overrun_set;
            host_break   <= brk_hit;
        end
    end

    uart_rx_fifo #(.DEPTH(RX_FIFO_DEPTH)) u_rx_fifo (
        .clk       (clk),
        .rstn      (rstn),
        .push      (rx_push),
        .push_data (rx_shift),
        .pop       (rx_ready),
        .pop_data  (rx_data),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign rx_valid = !fifo_empty;

    // ---------------- TX ----------------
    uart_tx_state_t tx_state, tx_state_nxt;
    logic [CW-1:0]  tx_cnt;
    logic [2:0]     tx_bit;
    byte_t          tx_shift;
    logic           tx_full;

    assign tx_full = (tx_cnt == CNT_FULL);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) tx_state <= TX_IDLE;
        else       tx_state <= tx_state_nxt;
    end

    always_comb begin
        tx_state_nxt = tx_state;
        case (tx_state)
            TX_IDLE:  if (tx_valid) tx_state_nxt = TX_START;
            TX_START: if (tx_full) tx_state_nxt = TX_DATA;
            TX_DATA:  if (tx_full && tx_bit == 3'd7) tx_state_nxt = TX_STOP;
            TX_STOP:  if (tx_full) tx_state_nxt = TX_IDLE;
            default:  tx_state_nxt = TX_IDLE;
        endcase
    end

    always_comb begin
        tx_ready = (tx_state == TX_IDLE);
        case (tx_state)
            TX_START: uart_tx = 1'b0;
            TX_DATA:  uart_tx = tx_shift[0];
            default:  uart_tx = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_shift <= '0;
        end else begin
            case (tx_state)
                TX_IDLE: begin
                    tx_cnt <= '0;
                    tx_bit <= '0;
                    if (tx_valid) tx_shift <= tx_data;
                end
                TX_DATA: begin
                    if (tx_full) begin
                        tx_cnt   <= '0;
                        tx_bit   <= tx_bit + 1'b1;
                        tx_shift <= {1'b0, tx_shift[7:1]};
                    end else begin
                        tx_cnt <= tx_cnt + 1'b1;
                    end
                end
                default: tx_cnt <= tx_full ? '0 : tx_cnt + 1'b1;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_cmd_bridge.sv
// Bench for uart_cmd_bridge at CLKS_PER_BIT=8, RX_FIFO_DEPTH=4.
// Break scenario follows BREAK_DETECT_EN in the same way as the design.
module tb_uart_cmd_bridge;
    import uart_pkg::*;

    localparam int CPB   = 8;
    localparam int DEPTH = 4;

    logic       clk;
    logic       rstn;
    logic       uart_rx;
    logic       uart_tx;
    logic       rx_valid;
    logic       rx_ready;
    logic [7:0] rx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] tx_data;
    logic       rx_frame_err;
    logic       rx_overrun;
    logic       host_break;

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    logic       tx_exp_q[$];

    int fe_cnt = 0;
    int ov_cnt = 0;
    int hb_cnt = 0;
    int hb_cyc = 0;
    int cyc    = 0;

    uart_cmd_bridge #(.CLKS_PER_BIT(CPB), .RX_FIFO_DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rstn         (rstn),
        .uart_rx      (uart_rx),
        .uart_tx      (uart_tx),
        .rx_valid     (rx_valid),
        .rx_ready     (rx_ready),
        .rx_data      (rx_data),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready),
        .tx_data      (tx_data),
        .rx_frame_err (rx_frame_err),
        .rx_overrun   (rx_overrun),
        .host_break   (host_break)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (rx_valid && rx_ready) got_q.push_back(rx_data);
        if (rx_frame_err) fe_cnt++;
        if (rx_overrun)   ov_cnt++;
        if (host_break) begin
            hb_cnt++;
            hb_cyc = cyc;
        end
    end

    // ---------------- drivers ----------------
    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Drives one 8N1 frame starting at a negedge; leaves the line high.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        logic [9:0] frame;
        frame = {stop_bit, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            uart_rx = frame[i];
            repeat (CPB) @(negedge clk);
        end
        uart_rx = 1'b1;
    endtask

    task automatic drain_check(input int n, input string name);
        logic [7:0] exp_b;
        logic [7:0] got_b;
        rx_ready = 1'b1;
        for (int t = 0; t < 40 * n + 20 && got_q.size() < n; t++) @(negedge clk);
        rx_ready = 1'b0;
        n_checks++;
        if (got_q.size() !== n)
            $display("FAIL %s_count: got %0d bytes, expected %0d", name, got_q.size(), n);
        else
            n_pass++;
        for (int i = 0; i < n; i++) begin
            exp_b = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
            got_b = (got_q.size() > 0) ? got_q.pop_front() : 8'hxx;
            n_checks++;
            if (got_b !== exp_b)
                $display("FAIL %s_byte%0d: got %02h, expected %02h", name, i, got_b, exp_b);
            else
                n_pass++;
        end
        got_q.delete();
        idle(2);
        n_checks++;
        if (rx_valid !== 1'b0)
            $display("FAIL %s_empty: rx_valid=%b, expected 0", name, rx_valid);
        else
            n_pass++;
    endtask

    task automatic tx_send_check(input logic [7:0] b, input string name);
        logic [9:0] frame;
        logic       exp_bit;
        int         lo;
        frame = {1'b1, b, 1'b0};
        lo = 0;
        for (int i = 0; i < 10; i++) tx_exp_q.push_back(frame[i]);
        @(negedge clk);
        tx_data  = b;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        tx_data  = ~b;
        for (int k = 1; k <= 81; k++) begin
            if (k > 1) @(negedge clk);
            if (k <= 80 && !tx_ready) lo++;
            if (k <= 80 && (k % 8) == 4) begin
                exp_bit = tx_exp_q.pop_front();
                n_checks++;
                if (uart_tx !== exp_bit)
                    $display("FAIL %s_bit%0d: uart_tx=%b, expected %b", name, k / 8, uart_tx, exp_bit);
                else
                    n_pass++;
            end
        end
        n_checks++;
        if (lo !== 80) $display("FAIL %s_busy: tx_ready low %0d cycles, expected 80", name, lo);
        else n_pass++;
        n_checks++;
        if (tx_ready !== 1'b1 || uart_tx !== 1'b1)
            $display("FAIL %s_done: tx_ready=%b uart_tx=%b, expected 1 1", name, tx_ready, uart_tx);
        else
            n_pass++;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rstn     = 1'b0;
        uart_rx  = 1'b1;
        rx_ready = 1'b0;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        idle(3);
        n_checks++;
        if ({uart_tx, rx_valid, rx_data, tx_ready, rx_frame_err, rx_overrun, host_break} !== {1'b1, 1'b0, 8'h00, 1'b1, 3'b000})
            $display("FAIL reset_outputs: uart_tx=%b rx_valid=%b rx_data=%02h tx_ready=%b pulses=%b%b%b, expected 1 0 00 1 000",
                     uart_tx, rx_valid, rx_data, tx_ready, rx_frame_err, rx_overrun, host_break);
        else
            n_pass++;
        rstn = 1'b1;
        idle(4);
    endtask

    task automatic test_single_rx();
        int fe0, ov0;
        fe0 = fe_cnt;
        ov0 = ov_cnt;
        exp_q.push_back(8'hA5);
        send_frame(8'hA5, 1'b1);
        n_checks++;
        if (rx_valid !== 1'b1 || rx_data !== 8'hA5)
            $display("FAIL single_rx_head: rx_valid=%b rx_data=%02h, expected 1 a5", rx_valid, rx_data);
        else
            n_pass++;
        idle(4);
        n_checks++;
        if (fe_cnt !== fe0 || ov_cnt !== ov0)
            $display("FAIL single_rx_pulses: frame_err=%0d overrun=%0d, expected 0 0", fe_cnt - fe0, ov_cnt - ov0);
        else
            n_pass++;
        drain_check(1, "single_rx");
    endtask

    task automatic test_overrun();
        int ov0;
        ov0 = ov_cnt;
        for (int i = 1; i <= 5; i++) begin
            if (i <= DEPTH) exp_q.push_back(8'(i));
            send_frame(8'(i), 1'b1);
            if (i == DEPTH) begin
                n_checks++;
                if (ov_cnt !== ov0) $display("FAIL overrun_early: %0d pulses before fifo full, expected 0", ov_cnt - ov0);
                else n_pass++;
            end
        end
        idle(4);
        n_checks++;
        if (ov_cnt - ov0 !== 1) $display("FAIL overrun_pulse: %0d pulses, expected 1", ov_cnt - ov0);
        else n_pass++;
        drain_check(DEPTH, "overrun");
    endtask

    task automatic test_frame_err();
        int fe0;
        fe0 = fe_cnt;
        send_frame(8'h3C, 1'b0);
        idle(4);
        n_checks++;
        if (fe_cnt - fe0 !== 1 || rx_valid !== 1'b0)
            $display("FAIL frame_err_pulse: pulses=%0d rx_valid=%b, expected 1 0", fe_cnt - fe0, rx_valid);
        else
            n_pass++;
        exp_q.push_back(8'h7E);
        send_frame(8'h7E, 1'b1);
        idle(4);
        n_checks++;
        if (fe_cnt - fe0 !== 1) $display("FAIL frame_err_recover: pulses=%0d, expected 1", fe_cnt - fe0);
        else n_pass++;
        drain_check(1, "frame_err");
    endtask

    task automatic test_glitch();
        int fe0, ov0;
        fe0 = fe_cnt;
        ov0 = ov_cnt;
        uart_rx = 1'b0;
        idle(3);
        uart_rx = 1'b1;
        idle(20);
        n_checks++;
        if (fe_cnt !== fe0 || ov_cnt !== ov0 || rx_valid !== 1'b0)
            $display("FAIL glitch_quiet: frame_err=%0d overrun=%0d rx_valid=%b, expected 0 0 0", fe_cnt - fe0, ov_cnt - ov0, rx_valid);
        else
            n_pass++;
        n_checks++;
        if (dut.rx_state !== RX_IDLE) $display("FAIL glitch_state: rx_state=%0d, expected %0d", dut.rx_state, RX_IDLE);
        else n_pass++;
    endtask

    task automatic test_tx();
        tx_send_check(8'h96, "tx96");
    endtask

    task automatic test_back_to_back();
        logic [7:0] rb, tb_byte;
        rb      = 8'($urandom_range(0, 255));
        tb_byte = 8'($urandom_range(0, 255));
        exp_q.push_back(rb);
        fork
            send_frame(rb, 1'b1);
            tx_send_check(tb_byte, "duplex_tx");
        join
        idle(4);
        drain_check(1, "duplex_rx");
    endtask

    task automatic test_break();
        int fe0, hb0, start;
        fe0 = fe_cnt;
        hb0 = hb_cnt;
        uart_rx = 1'b0;
        start = cyc;
        idle(200);
        n_checks++;
        if (dut.rx_state !== RX_WAIT_IDLE) $display("FAIL break_state: rx_state=%0d, expected %0d", dut.rx_state, RX_WAIT_IDLE);
        else n_pass++;
        uart_rx = 1'b1;
        idle(10);
        n_checks++;
        if (fe_cnt - fe0 !== 1 || rx_valid !== 1'b0)
            $display("FAIL break_frame_err: pulses=%0d rx_valid=%b, expected 1 0", fe_cnt - fe0, rx_valid);
        else
            n_pass++;
`ifdef BREAK_DETECT_EN
        n_checks++;
        if (hb_cnt - hb0 !== 1) $display("FAIL break_pulse: %0d pulses, expected 1", hb_cnt - hb0);
        else n_pass++;
        n_checks++;
        if (hb_cyc - start < 20 * CPB || hb_cyc - start > 20 * CPB + 6)
            $display("FAIL break_time: pulse %0d cycles after line low, expected %0d..%0d", hb_cyc - start, 20 * CPB, 20 * CPB + 6);
        else
            n_pass++;
`else
        n_checks++;
        if (hb_cnt !== hb0) $display("FAIL break_disabled: %0d host_break pulses, expected 0", hb_cnt - hb0);
        else n_pass++;
`endif
        idle(4);
    endtask

    initial begin
        test_reset();
        test_single_rx();
        test_overrun();
        test_frame_err();
        test_glitch();
        test_tx();
        test_back_to_back();
        test_break();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
